// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - front-panel controller for the stopwatch datapath
// Turns button presses into start/reset controls, latches the select, captures and holds lap times.
module stopwatch_ctrl #(
  parameter int HOLD_CYCLES = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic [1:0] mode_sel,
  input  logic [5:0] sw_hours,
  input  logic [5:0] sw_minutes,
  input  logic [5:0] sw_seconds,
  input  logic [6:0] sw_ms,
  output logic       sw_start,
  output logic       sw_reset,
  output logic [1:0] sw_sel,
  output logic [5:0] disp_hours,
  output logic [5:0] disp_minutes,
  output logic [5:0] disp_seconds,
  output logic [6:0] disp_ms,
  output logic [3:0] lap_count,
  output logic       lap_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [9:0] HOLD_LOAD = 10'(HOLD_CYCLES - 1);

  state_t     cur_state, nxt_state;
  logic       prev_ss, prev_lap, prev_clr;
  logic       edge_ss, edge_lap, edge_clr;
  logic       act_ss, act_lap, act_clr;
  logic [1:0] clr_cnt;
  logic [9:0] hold_cnt;
  logic [5:0] lap_hours, lap_minutes, lap_seconds;
  logic [6:0] lap_ms;
  logic       start_nxt, load_sel, capture, enter_clear;

  assign edge_ss  = btn_ss  & ~prev_ss;
  assign edge_lap = btn_lap & ~prev_lap;
  assign edge_clr = btn_clr & ~prev_clr;

  // Priority is resolved on raw presses: a lower-priority press is dropped even if the winner is ignored.
  assign act_clr = edge_clr;
  assign act_ss  = edge_ss & ~edge_clr;
  assign act_lap = edge_lap & ~edge_clr & ~edge_ss;

  always_comb begin
    nxt_state = cur_state;
    start_nxt = 1'b0;
    load_sel  = 1'b0;
    capture   = 1'b0;
    case (cur_state)
      IDLE: begin
        if (act_clr) begin
          nxt_state = CLEAR;
        end else if (act_ss) begin
          nxt_state = RUN;
          start_nxt = 1'b1;
          load_sel  = 1'b1;
        end
      end
      RUN: begin
        if (act_ss) begin
          nxt_state = PAUSE;
          start_nxt = 1'b1;
        end else if (act_lap) begin
          capture = 1'b1;
        end
      end
      PAUSE: begin
        if (act_clr) begin
          nxt_state = CLEAR;
        end else if (act_ss) begin
          nxt_state = RUN;
          start_nxt = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt == 2'd1) nxt_state = IDLE;
      end
      default: nxt_state = CLEAR;
    endcase
  end

  assign enter_clear = (nxt_state == CLEAR) && (cur_state != CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= CLEAR;
      clr_cnt   <= 2'd0;
      prev_ss   <= 1'b0;
      prev_lap  <= 1'b0;
      prev_clr  <= 1'b0;
      sw_start  <= 1'b0;
      sw_sel    <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      prev_ss   <= btn_ss;
      prev_lap  <= btn_lap;
      prev_clr  <= btn_clr;
      sw_start  <= start_nxt;
      if (load_sel) sw_sel <= mode_sel;
      clr_cnt <= (cur_state == CLEAR && nxt_state == CLEAR) ? clr_cnt + 2'd1 : 2'd0;
    end
  end

  // Hold runs independently of RUN/PAUSE; only CLEAR (or reset) cancels it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_count   <= 4'd0;
      lap_hold    <= 1'b0;
      hold_cnt    <= 10'd0;
      lap_hours   <= 6'd0;
      lap_minutes <= 6'd0;
      lap_seconds <= 6'd0;
      lap_ms      <= 7'd0;
    end else if (enter_clear) begin
      lap_count   <= 4'd0;
      lap_hold    <= 1'b0;
      hold_cnt    <= 10'd0;
      lap_hours   <= 6'd0;
      lap_minutes <= 6'd0;
      lap_seconds <= 6'd0;
      lap_ms      <= 7'd0;
    end else if (capture) begin
      lap_hours   <= sw_hours;
      lap_minutes <= sw_minutes;
      lap_seconds <= sw_seconds;
      lap_ms      <= sw_ms;
      hold_cnt    <= HOLD_LOAD;
      lap_hold    <= 1'b1;
      if (lap_count != 4'd15) lap_count <= lap_count + 4'd1;
    end else if (lap_hold) begin
      if (hold_cnt == 10'd0) lap_hold <= 1'b0;
      else                   hold_cnt <= hold_cnt - 10'd1;
    end
  end

  assign sw_reset     = (cur_state == CLEAR);
  assign state        = cur_state;
  assign disp_hours   = lap_hold ? lap_hours   : sw_hours;
  assign disp_minutes = lap_hold ? lap_minutes : sw_minutes;
  assign disp_seconds = lap_hold ? lap_seconds : sw_seconds;
  assign disp_ms      = lap_hold ? lap_ms      : sw_ms;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
// Directed scenarios plus random button traffic, all compared each cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int HOLD = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_ss, btn_lap, btn_clr;
  logic [1:0] mode_sel;
  logic [5:0] sw_hours, sw_minutes, sw_seconds;
  logic [6:0] sw_ms;
  logic       sw_start, sw_reset, lap_hold;
  logic [1:0] sw_sel, state;
  logic [5:0] disp_hours, disp_minutes, disp_seconds;
  logic [6:0] disp_ms;
  logic [3:0] lap_count;

  int checks = 0;
  int failures = 0;
  bit live_rand = 1'b1;

  // behavioural model
  int          m_state, m_clr_left, m_hold_left, m_count;
  bit          m_start;
  logic [1:0]  m_sel;
  logic [24:0] m_lap;
  bit          p_ss, p_lap, p_clr;

  stopwatch_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset),
    .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .mode_sel(mode_sel),
    .sw_hours(sw_hours), .sw_minutes(sw_minutes), .sw_seconds(sw_seconds), .sw_ms(sw_ms),
    .sw_start(sw_start), .sw_reset(sw_reset), .sw_sel(sw_sel),
    .disp_hours(disp_hours), .disp_minutes(disp_minutes), .disp_seconds(disp_seconds), .disp_ms(disp_ms),
    .lap_count(lap_count), .lap_hold(lap_hold), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] live();
    return {sw_hours, sw_minutes, sw_seconds, sw_ms};
  endfunction

  function automatic logic [24:0] shown();
    return {disp_hours, disp_minutes, disp_seconds, disp_ms};
  endfunction

  task automatic model_reset();
    m_state = 3; m_clr_left = 2; m_start = 0; m_sel = 2'd0;
    m_count = 0; m_hold_left = 0; m_lap = '0;
    p_ss = 0; p_lap = 0; p_clr = 0;
  endtask

  task automatic model_step();
    bit e_ss, e_lap, e_clr, to_clear, cap;
    e_ss = btn_ss && !p_ss; e_lap = btn_lap && !p_lap; e_clr = btn_clr && !p_clr;
    p_ss = btn_ss; p_lap = btn_lap; p_clr = btn_clr;
    m_start = 0; to_clear = 0; cap = 0;
    if (m_state == 3) begin
      m_clr_left--;
      if (m_clr_left == 0) m_state = 0;
    end else if (e_clr) begin
      if (m_state != 1) to_clear = 1;
    end else if (e_ss) begin
      m_start = 1;
      if (m_state == 0) begin m_sel = mode_sel; m_state = 1; end
      else if (m_state == 1) m_state = 2;
      else m_state = 1;
    end else if (e_lap && m_state == 1) begin
      cap = 1;
    end
    if (to_clear) begin
      m_state = 3; m_clr_left = 2; m_count = 0; m_hold_left = 0; m_lap = '0;
    end else if (cap) begin
      m_lap = live();
      if (m_count < 15) m_count++;
      m_hold_left = HOLD;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_state));
    chk("sw_start", 32'(sw_start), 32'(m_start));
    chk("sw_reset", 32'(sw_reset), 32'(m_state == 3));
    chk("sw_sel", 32'(sw_sel), 32'(m_sel));
    chk("lap_count", 32'(lap_count), 32'(m_count));
    chk("lap_hold", 32'(lap_hold), 32'(m_hold_left > 0));
    chk("disp", 32'(shown()), 32'((m_hold_left > 0) ? m_lap : live()));
  endtask

  task automatic new_time();
    if (live_rand) begin
      sw_hours   = 6'($urandom_range(0, 63));
      sw_minutes = 6'($urandom_range(0, 59));
      sw_seconds = 6'($urandom_range(0, 59));
      sw_ms      = 7'($urandom_range(0, 99));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!reset) model_reset();
    else model_step();
    compare_all();
    new_time();
  endtask

  task automatic press_ss();
    btn_ss = 1'b1; cyc(); btn_ss = 1'b0; cyc();
  endtask

  task automatic press_lap();
    btn_lap = 1'b1; cyc(); btn_lap = 1'b0; cyc();
  endtask

  initial begin
    int pulses;
    reset = 1'b0; btn_ss = 0; btn_lap = 0; btn_clr = 0; mode_sel = 2'd0;
    new_time();
    model_reset();

    // power-up
    repeat (3) cyc();
    chk("por_sw_reset", 32'(sw_reset), 32'd1);
    reset = 1'b1;
    cyc();
    chk("por_hold_sw_reset", 32'(sw_reset), 32'd1);
    cyc();
    chk("por_idle", 32'(state), 32'd0);
    chk("por_count", 32'(lap_count), 32'd0);

    // start/stop and select latching
    mode_sel = 2'd1;
    btn_ss = 1'b1; cyc();
    chk("ss1_start", 32'(sw_start), 32'd1);
    chk("ss1_state", 32'(state), 32'd1);
    btn_ss = 1'b0; cyc();
    chk("ss1_one_pulse", 32'(sw_start), 32'd0);
    repeat (500) cyc();
    press_ss();
    chk("ss2_state", 32'(state), 32'd2);
    repeat (5) cyc();
    press_ss();
    chk("ss3_state", 32'(state), 32'd1);
    mode_sel = 2'd2;
    repeat (4) cyc();
    chk("sel_locked", 32'(sw_sel), 32'd1);

    // lap capture and hold length
    live_rand = 1'b0;
    sw_hours = 6'd0; sw_minutes = 6'd0; sw_seconds = 6'd3; sw_ms = 7'd27;
    btn_lap = 1'b1; cyc();
    chk("lap_disp", 32'(shown()), {7'd0, 6'd0, 6'd0, 6'd3, 7'd27});
    chk("lap_count1", 32'(lap_count), 32'd1);
    live_rand = 1'b1; new_time();
    btn_lap = 1'b0;
    repeat (HOLD - 1) cyc();
    chk("hold_last", 32'(lap_hold), 32'd1);
    cyc();
    chk("hold_end", 32'(lap_hold), 32'd0);
    repeat (17) press_lap();
    chk("lap_sat", 32'(lap_count), 32'd15);

    // clr alone in RUN is ignored
    btn_clr = 1'b1; cyc(); btn_clr = 1'b0; cyc();
    chk("clr_in_run", 32'(state), 32'd1);

    // simultaneous clr+ss in PAUSE
    press_ss();
    btn_clr = 1'b1; btn_ss = 1'b1; cyc();
    chk("simul_state", 32'(state), 32'd3);
    chk("simul_no_start", 32'(sw_start), 32'd0);
    btn_clr = 1'b0; btn_ss = 1'b0; cyc();
    chk("simul_reset2", 32'(sw_reset), 32'd1);
    cyc();
    chk("simul_idle", 32'(state), 32'd0);
    chk("simul_count", 32'(lap_count), 32'd0);

    // held start/stop
    pulses = 0;
    btn_ss = 1'b1;
    repeat (50) begin cyc(); pulses += int'(sw_start); end
    btn_ss = 1'b0; cyc();
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_state", 32'(state), 32'd1);

    // async reset mid-hold
    press_lap();
    repeat (10) cyc();
    #2 reset = 1'b0;
    #1 model_reset();
    chk("rst_hold", 32'(lap_hold), 32'd0);
    chk("rst_disp_live", 32'(shown()), 32'(live()));
    chk("rst_sw_reset", 32'(sw_reset), 32'd1);
    compare_all();
    cyc();
    reset = 1'b1;
    cyc();
    chk("rst_seq", 32'(sw_reset), 32'd1);
    cyc();
    chk("rst_idle", 32'(state), 32'd0);

    // random traffic
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_ss = ~btn_ss;
      if ($urandom_range(0, 5) == 0) btn_lap = ~btn_lap;
      if (btn_clr) btn_clr = ($urandom_range(0, 1) == 0);
      else         btn_clr = ($urandom_range(0, 59) == 0);
      mode_sel = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-panel controller for the `stopwatch` datapath. It converts three push-button levels (start/stop, lap, clear) into the stopwatch's single-cycle `start` toggle pulse and its active-high `reset`, and latches the configuration select while the stopwatch is stopped. It also captures lap times and muxes a frozen lap value or the live time onto the display bus. It sits between the board I/O and `stopwatch`, in the same 100 Hz clock domain.

## Interface
- `HOLD_CYCLES`, 300, number of cycles a captured lap is shown on the display (3 s at 100 Hz); legal range 1..1023.
- `clk`  in  1  system clock (100 Hz, shared with `stopwatch`).
- `reset`  in  1  asynchronous, active-low reset.
- `btn_ss`  in  1  start/stop button level, already synchronized.
- `btn_lap`  in  1  lap button level, already synchronized.
- `btn_clr`  in  1  clear button level, already synchronized.
- `mode_sel`  in  2  requested stopwatch configuration select.
- `sw_hours`, `sw_minutes`, `sw_seconds`  in  6 each  live time from `stopwatch`.
- `sw_ms`  in  7  live hundredths from `stopwatch`.
- `sw_start`  out  1  one-cycle toggle pulse to `stopwatch.start`.
- `sw_reset`  out  1  active-high reset to `stopwatch.reset`.
- `sw_sel`  out  2  latched select to `stopwatch.sel`.
- `disp_hours`, `disp_minutes`, `disp_seconds`  out  6 each  display time.
- `disp_ms`  out  7  display hundredths.
- `lap_count`  out  4  number of laps captured since clear; saturates at 15.
- `lap_hold`  out  1  high while the display shows a captured lap.
- `state`  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, CLEAR=3.

## Operation
- Edge detect: one previous-value register per button, reset value 0. A press is `btn & ~prev`, evaluated at the sampling clock edge.
- Simultaneous presses in one cycle: only the highest-priority press acts, in the order clr > ss > lap. The others are dropped.
- IDLE:
  - ss press: pulse `sw_start`, load `sw_sel <= mode_sel`, go to RUN.
  - clr press: go to CLEAR.
  - lap press: ignored.
- RUN:
  - ss press: pulse `sw_start`, go to PAUSE.
  - lap press: capture the `sw_*` values sampled at that edge into the lap register, `lap_count += 1` (saturating at 15), load the hold counter with `HOLD_CYCLES-1`, set `lap_hold`.
  - clr press: ignored.
- PAUSE:
  - ss press: pulse `sw_start`, go to RUN. `sw_sel` is not reloaded.
  - clr press: go to CLEAR.
  - lap press: ignored.
- CLEAR:
  - `sw_reset` is high for exactly 2 cycles (2-bit counter).
  - Lap register, `lap_count`, `lap_hold` and hold counter are cleared on entry.
  - Then go to IDLE. All presses are ignored in CLEAR.
- `mode_sel` changes while in RUN or PAUSE have no effect on `sw_sel`.
- Hold counter:
  - Decrements each cycle while `lap_hold` = 1; `lap_hold` clears on the cycle after the counter reads 0.
  - The hold runs independently of RUN/PAUSE transitions and is cancelled only by CLEAR.
  - A lap press during a hold recaptures the lap and reloads the counter.
- Display: combinational mux, `disp_* = lap_hold ? lap_reg : sw_*`.

## Timing
- All state is in flops on `clk` rising edge; `reset` low clears asynchronously.
- Reset values:
  - `state` = CLEAR, clear counter = 0, `sw_reset` = 1, `sw_start` = 0, `sw_sel` = 0.
  - `lap_count` = 0, `lap_hold` = 0, lap register = 0, button prev registers = 0.
- After `reset` rises, `sw_reset` stays high for 2 more cycles, then `state` = IDLE. The datapath is therefore always cleared after power-up.
- Press latency: a press sampled at edge k gives `sw_start` high during cycle k..k+1 only; `state` updates at edge k.
- `sw_start` is never high in 2 consecutive cycles. A held button produces exactly one action.
- Lap capture: the value sampled at edge k appears on `disp_*` from cycle k and is held for exactly `HOLD_CYCLES` cycles.
- Reset asserted mid-CLEAR or mid-hold: immediate return to the reset values, then the normal 2-cycle `sw_reset` sequence.

## Test plan
- Power-up: hold `reset` = 0 for 3 cycles, release -> `sw_reset` = 1 for 2 cycles, then `state` = 0, `sw_start` = 0, `lap_count` = 0.
- Start/stop: `mode_sel` = 1, press ss, wait 500 cycles, press ss, wait 5, press ss -> three single-cycle `sw_start` pulses, states 1, 2, 1, `sw_sel` = 1. Change `mode_sel` to 2 while running -> `sw_sel` stays 1.
- Lap: running at 00:00:03.27, press lap -> `disp_*` = 0/0/3/27 for exactly 300 cycles, `lap_count` = 1, then live. Press lap 17 times -> `lap_count` = 15.
- Simultaneous: in PAUSE, raise clr and ss in the same cycle -> `state` = 3, no `sw_start`, `sw_reset` high for 2 cycles, `lap_count` = 0, then IDLE. In RUN, clr alone -> ignored.
- Held button: hold ss high for 50 cycles from IDLE -> exactly one `sw_start` pulse, `state` = 1.
- Reset mid-hold: capture a lap, assert `reset` 10 cycles later -> `lap_hold` = 0 and `disp_*` = live immediately, followed by the post-reset `sw_reset` sequence.
